// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch stage feeding the decoder. Holds the fetch
//                PC, issues word reads to instruction memory with at most one
//                request outstanding, buffers returned {pc, instruction} pairs
//                in a small FIFO and presents the head entry to decode with a
//                valid/ready handshake. A redirect flushes the stage and
//                restarts fetch at the new address.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC        fetch address after reset
//    DEPTH           fetch-buffer entries (2..4)
//  Ports
//    clk             clock, rising edge
//    rst             asynchronous reset, active-high
//    imem_req        read request to instruction memory
//    imem_addr       word address of the request
//    imem_gnt        memory accepts the request this cycle
//    imem_rvalid     read data valid
//    imem_rdata      instruction word from memory
//    redirect_valid  branch/jump taken: flush and restart fetch
//    redirect_pc     new fetch address (low two bits ignored)
//    inst_valid      inst_r/pc_r hold a valid instruction
//    inst_ready      decode consumes the head entry this cycle
//    inst_r          instruction to decoder (NOP when empty)
//    pc_r            PC of inst_r (0 when empty)
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_r,
  output logic [31:0] pc_r
);

  localparam int          PW         = (DEPTH > 2) ? 2 : 1;
  localparam logic [1:0]  S_REQ      = 2'd0;
  localparam logic [1:0]  S_WAIT     = 2'd1;
  localparam logic [1:0]  S_DROP     = 2'd2;
  localparam logic [31:0] c_nop      = 32'h0000_0013;
  localparam logic [2:0]  c_depth    = 3'(DEPTH);
  localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_pc_q;
  logic [2:0]    count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic grant;
  logic push;
  logic pop;

  // Only the word-aligned part of a redirect target is used.
  logic w_unused_redirect_bits;
  assign w_unused_redirect_bits = ^redirect_pc[1:0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        // imem_req is already suppressed during a redirect, so no grant then.
        if (grant) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)         state_d = S_REQ;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    push     = 1'b0;
    case (state_q)
      S_REQ: begin
        // Buffer space for the response is reserved at request time using the
        // registered count only; a same-cycle pop does not open a slot early.
        // Gating with rst keeps the request low while reset is held.
        imem_req = (count_q < c_depth) & ~redirect_valid & ~rst;
      end
      S_WAIT: begin
        // A response arriving with a redirect belongs to the old path.
        push = imem_rvalid & ~redirect_valid;
      end
      default: ;
    endcase
  end

  assign grant     = imem_req & imem_gnt;
  assign imem_addr = fetch_pc_q;

  // --------------------------------------------------------------------------
  // Fetch PC and in-flight PC
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;  // wraps naturally at 2^32
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= 32'h0000_0000;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (grant) begin
        inflight_pc_q <= fetch_pc_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetch buffer
  // --------------------------------------------------------------------------
  assign inst_valid = (count_q != 3'd0);
  // Flush takes priority over a pop in the same cycle.
  assign pop        = inst_valid & inst_ready & ~redirect_valid;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
    end else if (redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pc_mem_q[g]   <= 32'h0000_0000;
          inst_mem_q[g] <= c_nop;
        end else if (push && (wr_ptr_q == PW'(g))) begin
          pc_mem_q[g]   <= inflight_pc_q;
          inst_mem_q[g] <= imem_rdata;
        end
      end
    end
  endgenerate

  assign inst_r = inst_valid ? inst_mem_q[rd_ptr_q] : c_nop;
  assign pc_r   = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Directed self-checking bench for inst_fetch (DEPTH=2,
//                RESET_PC=0). Inputs change on the falling edge; outputs are
//                checked 1 time unit later, well away from the rising edge.
//                Memory returns ~addr so each word is tagged by its address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_r;
  logic [31:0] pc_r;

  int checks;
  int failures;

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_r         (inst_r),
    .pc_r           (pc_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expects to start on a falling edge in S_REQ with gnt=1. Checks the
  // request, lets it be granted, returns ~addr one cycle later, and ends on
  // the falling edge after the push (plus 1 time unit).
  task automatic fetch_one(input logic [31:0] addr);
    #1;
    chk("req_issue", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, addr);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = ~addr;
    #1;
    chk("req_in_wait", {31'd0, imem_req}, 32'd0);
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #1;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;

    // ---------------- Reset state ----------------
    #2;
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",  inst_r, 32'h0000_0013);
    chk("rst_pc",    pc_r,   32'h0000_0000);
    @(negedge clk);
    rst        = 1'b0;
    imem_gnt   = 1'b1;
    inst_ready = 1'b1;

    // ---------------- 1: streaming, ready=1 ----------------
    for (int i = 0; i < 4; i++) begin
      fetch_one(32'(i * 4));
      chk("t1_valid", {31'd0, inst_valid}, 32'd1);
      chk("t1_pc",    pc_r,   32'(i * 4));
      chk("t1_inst",  inst_r, ~32'(i * 4));
    end
    imem_gnt = 1'b0;
    step();
    #1;
    chk("t1_drain_valid", {31'd0, inst_valid}, 32'd0);
    chk("t1_drain_inst",  inst_r, 32'h0000_0013);
    chk("t1_drain_pc",    pc_r,   32'h0000_0000);

    // ---------------- 2: backpressure fills DEPTH=2 ----------------
    inst_ready     = 1'b0;
    imem_gnt       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0000;
    #1;
    chk("t2_redir_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    fetch_one(32'h0000_0000);
    fetch_one(32'h0000_0004);
    chk("t2_full_req",   {31'd0, imem_req},   32'd0);
    chk("t2_full_valid", {31'd0, inst_valid}, 32'd1);
    chk("t2_full_pc",    pc_r,   32'h0000_0000);
    chk("t2_full_inst",  inst_r, 32'hFFFF_FFFF);
    step();
    #1;
    chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
    chk("t2_hold_pc",  pc_r, 32'h0000_0000);
    inst_ready = 1'b1;
    step();
    #1;
    chk("t2_pop_pc",   pc_r,   32'h0000_0004);
    chk("t2_pop_inst", inst_r, 32'hFFFF_FFFB);
    chk("t2_next_req", {31'd0, imem_req}, 32'd1);
    chk("t2_next_addr", imem_addr, 32'h0000_0008);
    inst_ready = 1'b0;
    step();  // addr 8 granted, now in S_WAIT with pc 4 buffered

    // ---------------- 3: redirect during S_WAIT ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    chk("t3_redir_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3_flush_valid", {31'd0, inst_valid}, 32'd0);
    chk("t3_drop_req",    {31'd0, imem_req},   32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("t3_late_valid", {31'd0, inst_valid}, 32'd0);
    step();
    imem_rvalid = 1'b0;
    #1;
    chk("t3_after_valid", {31'd0, inst_valid}, 32'd0);
    chk("t3_after_req",   {31'd0, imem_req},   32'd1);
    chk("t3_after_addr",  imem_addr, 32'h0000_0100);

    // ---------------- 4: redirect + rvalid + pop same cycle ----------------
    fetch_one(32'h0000_0100);
    chk("t4_buf_pc", pc_r, 32'h0000_0100);
    step();  // addr 0x104 granted, S_WAIT, one entry buffered
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'hCAFE_F00D;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    inst_ready     = 1'b1;
    #1;
    chk("t4_req",   {31'd0, imem_req},   32'd0);
    chk("t4_valid", {31'd0, inst_valid}, 32'd1);
    step();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    #1;
    chk("t4_post_valid", {31'd0, inst_valid}, 32'd0);
    chk("t4_post_inst",  inst_r, 32'h0000_0013);
    chk("t4_post_req",   {31'd0, imem_req}, 32'd1);
    chk("t4_post_addr",  imem_addr, 32'h0000_0200);

    // ---------------- 5: PC wrap ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    fetch_one(32'hFFFF_FFFC);
    chk("t5_pc_top",   pc_r,   32'hFFFF_FFFC);
    chk("t5_inst_top", inst_r, 32'h0000_0003);
    fetch_one(32'h0000_0000);
    chk("t5_pc_wrap",   pc_r,   32'h0000_0000);
    chk("t5_inst_wrap", inst_r, 32'hFFFF_FFFF);

    // ---------------- 6: async reset mid-S_WAIT ----------------
    inst_ready = 1'b0;
    step();  // addr 4 granted, entry for pc 0 kept
    #1;
    chk("t6_pre_valid", {31'd0, inst_valid}, 32'd1);
    chk("t6_pre_inst",  inst_r, 32'hFFFF_FFFF);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_req",   {31'd0, imem_req},   32'd0);
    chk("t6_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_rst_inst",  inst_r, 32'h0000_0013);
    chk("t6_rst_pc",    pc_r,   32'h0000_0000);
    @(negedge clk);
    rst         = 1'b0;
    imem_rvalid = 1'b1;  // stale response from the abandoned request
    imem_rdata  = 32'h0BAD_0BAD;
    #1;
    chk("t6_rel_req",   {31'd0, imem_req},   32'd1);
    chk("t6_rel_addr",  imem_addr, 32'h0000_0000);
    chk("t6_rel_valid", {31'd0, inst_valid}, 32'd0);
    step();
    imem_rvalid = 1'b0;
    #1;
    chk("t6_stale_valid", {31'd0, inst_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
